// File: rtl/cpu_pkg.sv
// Shared CPU types: word/register widths, MEM-stage FSM states and the
// memory/writeback payload carried into the writeback stage.
package cpu_pkg;
    localparam int WORD_W          = 32;
    localparam int REG_ADDR_W      = 5;
    localparam int DEFAULT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic [WORD_W-1:0]     read_data;
        logic [WORD_W-1:0]     alu_result;
        logic [REG_ADDR_W-1:0] write_reg_addr;
        logic                  mem_reg;
        logic                  reg_write;
    } mw_t;
endpackage

// File: rtl/mw_pipeline_register.sv
// Memory/writeback boundary register, 1-cycle latency; a bubble clears only the
// control bits so the data fields simply hold while the stage is stalled.
module mw_pipeline_register
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic bubble,
    input  mw_t  d,
    output mw_t  q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (bubble) begin
            q.mem_reg   <= 1'b0;
            q.reg_write <= 1'b0;
        end else if (load) begin
            q <= d;
        end
    end
endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: IDLE/ACCESS/DONE handshake with data memory, 1 cycle for non-memory ops,
// 3+ cycles for aligned loads/stores; stall holds upstream until the access completes.
module mem_access_stage
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_W-1:0]     alu_result,
    input  logic                  alu_zero,
    input  logic [WORD_W-1:0]     branch_result,
    input  logic [REG_ADDR_W-1:0] write_reg_addr,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  mem_reg,
    input  logic                  branch,
    input  logic                  reg_write,
    input  logic [WORD_W-1:0]     mem_write_data,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [WORD_W-1:0]     dmem_addr,
    output logic [WORD_W-1:0]     dmem_wdata,
    input  logic [WORD_W-1:0]     dmem_rdata,
    input  logic                  dmem_ready,
    output logic                  stall,
    output logic                  pc_src,
    output logic [WORD_W-1:0]     branch_target,
    output logic                  mem_error,
    output logic [WORD_W-1:0]     read_data_buffered,
    output logic [WORD_W-1:0]     alu_result_buffered,
    output logic [REG_ADDR_W-1:0] write_reg_addr_buffered,
    output logic                  mem_reg_buffered,
    output logic                  reg_write_buffered
);
    localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t        state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              we_q;
    logic [WORD_W-1:0] rdata_q;
    logic              timed_out;

    logic mem_op;
    logic misaligned;
    logic start;
    logic bubble;
    logic load;
    mw_t  mw_d;
    mw_t  mw_q;

    assign mem_op     = mem_read | mem_write;
    assign misaligned = alu_result[1:0] != 2'b00;
    assign start      = (state == IDLE) && mem_op && !misaligned;

    // Request side comes only from state and latches, so it cannot glitch with inputs.
    assign dmem_req   = (state == ACCESS);
    assign dmem_we    = dmem_req & we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign stall      = rst & (start | (state == ACCESS));

    assign pc_src        = branch & alu_zero;
    assign branch_target = branch_result;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            rdata_q   <= '0;
            timed_out <= 1'b0;
            mem_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt  <= '0;
                    timed_out <= 1'b0;
                    if (mem_op && misaligned) begin
                        mem_error <= 1'b1;
                    end else if (mem_op) begin
                        addr_q  <= alu_result;
                        wdata_q <= mem_write_data;
                        we_q    <= mem_write;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (dmem_ready) begin
                        rdata_q  <= we_q ? '0 : dmem_rdata;
                        wait_cnt <= '0;
                        state    <= DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        rdata_q   <= '0;
                        timed_out <= 1'b1;
                        mem_error <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bubble = start | (state == ACCESS);
    assign load   = !bubble;

    always_comb begin
        mw_d                = '0;
        mw_d.read_data      = (state == DONE) ? rdata_q : '0;
        mw_d.alu_result     = alu_result;
        mw_d.write_reg_addr = write_reg_addr;
        mw_d.mem_reg        = mem_reg;
        mw_d.reg_write      = reg_write
                              & !((state == DONE) && timed_out)
                              & !((state == IDLE) && mem_op && misaligned);
    end

    mw_pipeline_register u_mw_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .bubble (bubble),
        .d      (mw_d),
        .q      (mw_q)
    );

    assign read_data_buffered      = mw_q.read_data;
    assign alu_result_buffered     = mw_q.alu_result;
    assign write_reg_addr_buffered = mw_q.write_reg_addr;
    assign mem_reg_buffered        = mw_q.mem_reg;
    assign reg_write_buffered      = mw_q.reg_write;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a per-instruction timeline model drives
// expectations that a single negedge process compares against the DUT.
`timescale 1ns/1ps
module tb_mem_access_stage;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_result, branch_result, mem_write_data, dmem_rdata;
    logic        alu_zero, mem_read, mem_write, mem_reg, branch, reg_write, dmem_ready;
    logic [4:0]  write_reg_addr;
    logic        dmem_req, dmem_we, stall, pc_src, mem_error, mem_reg_buffered, reg_write_buffered;
    logic [31:0] dmem_addr, dmem_wdata, branch_target, read_data_buffered, alu_result_buffered;
    logic [4:0]  write_reg_addr_buffered;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .alu_result(alu_result), .alu_zero(alu_zero), .branch_result(branch_result),
        .write_reg_addr(write_reg_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_reg(mem_reg), .branch(branch), .reg_write(reg_write),
        .mem_write_data(mem_write_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .stall(stall), .pc_src(pc_src), .branch_target(branch_target), .mem_error(mem_error),
        .read_data_buffered(read_data_buffered), .alu_result_buffered(alu_result_buffered),
        .write_reg_addr_buffered(write_reg_addr_buffered),
        .mem_reg_buffered(mem_reg_buffered), .reg_write_buffered(reg_write_buffered)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int req_cnt, stall_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected values, written by the timeline model in run_instr.
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_we, exp_pc, exp_mr, exp_rw, exp_err;
    logic [31:0] exp_addr, exp_wdata, exp_bt, exp_rd, exp_alu;
    logic [4:0]  exp_wra;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", stall, exp_stall);
            chk("dmem_req", dmem_req, exp_req);
            if (exp_req) begin
                chk("dmem_we", dmem_we, exp_we);
                chk("dmem_addr", dmem_addr, exp_addr);
                chk("dmem_wdata", dmem_wdata, exp_wdata);
            end
            chk("pc_src", pc_src, exp_pc);
            chk("branch_target", branch_target, exp_bt);
            chk("mem_error", mem_error, exp_err);
            chk("mem_reg_buffered", mem_reg_buffered, exp_mr);
            chk("reg_write_buffered", reg_write_buffered, exp_rw);
            chk("read_data_buffered", read_data_buffered, exp_rd);
            chk("alu_result_buffered", alu_result_buffered, exp_alu);
            chk("write_reg_addr_buffered", write_reg_addr_buffered, exp_wra);
            if (stall) stall_cnt++;
            if (dmem_req) req_cnt++;
        end
    end

    task automatic clear_model();
        exp_rd = '0; exp_alu = '0; exp_wra = '0; exp_mr = 1'b0; exp_rw = 1'b0; exp_err = 1'b0;
    endtask

    // One instruction held at the stage input until it leaves. waits = number of
    // ACCESS cycles with ready low before ready rises.
    task automatic run_instr(input logic [31:0] alu, input logic [4:0] wra,
                             input logic mr, input logic mw, input logic mreg, input logic rw,
                             input logic [31:0] wd, input int waits, input logic [31:0] rdat,
                             input logic br, input logic z, input logic [31:0] btgt);
        logic        memop, mis, tmo, in_access, res_rw;
        logic [31:0] res_rd;
        int          a, total;
        memop = mr | mw;
        mis   = memop && (alu[1:0] != 2'b00);
        if (memop && !mis) begin
            a     = (waits + 1 < T) ? waits + 1 : T;
            tmo   = (waits + 1 > T);
            total = a + 2;
        end else begin
            a = 0; tmo = 1'b0; total = 1;
        end
        res_rd = (memop && !mis && !mw && !tmo) ? rdat : 32'h0;
        res_rw = rw & !mis & !tmo;
        req_cnt = 0; stall_cnt = 0;
        alu_result = alu; write_reg_addr = wra; mem_read = mr; mem_write = mw;
        mem_reg = mreg; reg_write = rw; mem_write_data = wd;
        branch = br; alu_zero = z; branch_result = btgt;
        for (int c = 0; c < total; c++) begin
            in_access  = (c >= 1) && (c <= a);
            // Ready is also pulsed while idle; the stage must ignore it there.
            dmem_ready = in_access ? (c == waits + 1) : (c == 0);
            dmem_rdata = (c == waits + 1) ? rdat : 32'h0BAD_0000 + c;
            exp_stall  = (c < total - 1);
            exp_req    = in_access;
            exp_we     = mw;
            exp_addr   = alu;
            exp_wdata  = wd;
            exp_pc     = br & z;
            exp_bt     = btgt;
            chk_en     = 1'b1;
            @(posedge clk); #1;
            if (c == total - 1) begin
                exp_rd = res_rd; exp_alu = alu; exp_wra = wra; exp_mr = mreg; exp_rw = res_rw;
            end else begin
                exp_mr = 1'b0; exp_rw = 1'b0;
            end
            if (mis && c == 0) exp_err = 1'b1;
            if (tmo && c == a) exp_err = 1'b1;
        end
        chk_en     = 1'b0;
        dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst = 1'b0;
        #1;
        clear_model();
        chk("rst_mem_error", mem_error, 0);
        chk("rst_reg_write_b", reg_write_buffered, 0);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        alu_result = '0; branch_result = '0; mem_write_data = '0; dmem_rdata = '0;
        alu_zero = 0; mem_read = 0; mem_write = 0; mem_reg = 0; branch = 0; reg_write = 0;
        dmem_ready = 0; write_reg_addr = '0;
        clear_model();
        #2;
        chk("reset_stall", stall, 0);
        chk("reset_dmem_req", dmem_req, 0);
        chk("reset_dmem_we", dmem_we, 0);
        chk("reset_mem_error", mem_error, 0);
        chk("reset_read_data_b", read_data_buffered, 0);
        chk("reset_alu_result_b", alu_result_buffered, 0);
        chk("reset_wra_b", write_reg_addr_buffered, 0);
        chk("reset_mem_reg_b", mem_reg_buffered, 0);
        chk("reset_reg_write_b", reg_write_buffered, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // ALU op
        run_instr(32'h0000_0010, 5'd5, 0, 0, 0, 1, 32'h0, 0, 32'h0, 0, 0, 32'h0);
        chk("alu_stall_cycles", stall_cnt, 0);
        chk("alu_result_b", alu_result_buffered, 32'h10);
        chk("alu_wra_b", write_reg_addr_buffered, 5);
        chk("alu_reg_write_b", reg_write_buffered, 1);

        // Load with 2 wait states, branch taken throughout
        run_instr(32'h0000_0100, 5'd7, 1, 0, 1, 1, 32'h0, 2, 32'hDEAD_BEEF, 1, 1, 32'h0000_4000);
        chk("load_req_cycles", req_cnt, 3);
        chk("load_stall_cycles", stall_cnt, 4);
        chk("load_read_data_b", read_data_buffered, 32'hDEAD_BEEF);
        chk("load_mem_reg_b", mem_reg_buffered, 1);

        // Store, zero wait
        run_instr(32'h0000_0200, 5'd3, 0, 1, 0, 0, 32'hCAFE_0001, 0, 32'h1234_5678, 0, 1, 32'h0);
        chk("store_req_cycles", req_cnt, 1);
        chk("store_reg_write_b", reg_write_buffered, 0);
        chk("store_read_data_b", read_data_buffered, 0);

        // Branch decision is purely combinational
        branch = 1; alu_zero = 1; branch_result = 32'h0000_8888;
        #1;
        chk("branch_pc_src", pc_src, 1);
        chk("branch_target", branch_target, 32'h0000_8888);
        alu_zero = 0;
        #1;
        chk("branch_not_taken", pc_src, 0);

        // Read and write together: write wins, data 0
        run_instr(32'h0000_0300, 5'd9, 1, 1, 1, 1, 32'h55AA_55AA, 1, 32'h7777_7777, 0, 0, 32'h0);
        chk("rw_read_data_b", read_data_buffered, 0);

        // Misaligned load
        run_instr(32'h0000_0102, 5'd4, 1, 0, 1, 1, 32'h0, 0, 32'h0, 0, 0, 32'h0);
        chk("mis_req_cycles", req_cnt, 0);
        chk("mis_stall_cycles", stall_cnt, 0);
        chk("mis_mem_error", mem_error, 1);
        chk("mis_reg_write_b", reg_write_buffered, 0);

        do_reset();
        chk("post_reset_mem_error", mem_error, 0);

        // Ready on the last allowed ACCESS cycle is not a timeout
        run_instr(32'h0000_0400, 5'd6, 1, 0, 1, 1, 32'h0, T - 1, 32'h0000_00A5, 0, 0, 32'h0);
        chk("edge_req_cycles", req_cnt, 4);
        chk("edge_mem_error", mem_error, 0);
        chk("edge_read_data_b", read_data_buffered, 32'hA5);

        // Timeout
        run_instr(32'h0000_0500, 5'd8, 1, 0, 1, 1, 32'h0, 20, 32'h0000_0011, 0, 0, 32'h0);
        chk("tmo_req_cycles", req_cnt, 4);
        chk("tmo_mem_error", mem_error, 1);
        chk("tmo_read_data_b", read_data_buffered, 0);
        chk("tmo_reg_write_b", reg_write_buffered, 0);

        // Reset in the middle of an access
        alu_result = 32'h0000_0600; write_reg_addr = 5'd2; mem_read = 1; mem_write = 0;
        mem_reg = 1; reg_write = 1; dmem_ready = 0; branch = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_req_before", dmem_req, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_req_dropped", dmem_req, 0);
        chk("mid_stall_dropped", stall, 0);
        chk("mid_we", dmem_we, 0);
        chk("mid_mem_error", mem_error, 0);
        chk("mid_alu_result_b", alu_result_buffered, 0);
        chk("mid_read_data_b", read_data_buffered, 0);
        chk("mid_reg_write_b", reg_write_buffered, 0);
        chk("mid_mem_reg_b", mem_reg_buffered, 0);
        clear_model();
        @(posedge clk); #1;
        rst = 1'b1;
        run_instr(32'h0000_0020, 5'd11, 0, 0, 0, 1, 32'h0, 0, 32'h0, 0, 0, 32'h0);
        chk("after_reset_stall_cycles", stall_cnt, 0);
        chk("after_reset_alu_b", alu_result_buffered, 32'h20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage of the pipelined CPU, consuming the buffered outputs of the execute/memory pipeline register. Drives a request/ready data-memory port for loads and stores, stalls the upstream pipeline while an access is outstanding, resolves the branch decision, and registers results into the memory/writeback boundary.

## Interface
- `TIMEOUT`, 16: maximum number of ACCESS cycles without `dmem_ready` before the access is aborted. Must be ≥2.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `alu_result` input 32: effective address, or ALU value.
- `alu_zero` input 1: ALU zero flag.
- `branch_result` input 32: branch target.
- `write_reg_addr` input 5: destination register.
- `mem_read`, `mem_write`, `mem_reg`, `branch`, `reg_write` input 1 each: control bits from the execute/memory register.
- `mem_write_data` input 32: store data.
- `dmem_req` output 1: memory request.
- `dmem_we` output 1: write enable.
- `dmem_addr` output 32: word address.
- `dmem_wdata` output 32: write data.
- `dmem_rdata` input 32: read data, valid when `dmem_ready` is high.
- `dmem_ready` input 1: access complete.
- `stall` output 1: hold the PC and all upstream pipeline registers.
- `pc_src` output 1: take branch.
- `branch_target` output 32: equals `branch_result`.
- `mem_error` output 1: sticky error flag (misaligned address or timeout).
- `read_data_buffered`, `alu_result_buffered` output 32: memory/writeback payload.
- `write_reg_addr_buffered` output 5: memory/writeback destination register.
- `mem_reg_buffered`, `reg_write_buffered` output 1: memory/writeback control.

## Operation
- **Memory-op condition:** memory op = `mem_read | mem_write`. If both are set, write wins; `dmem_we` = 1 and the read data is 0.
- **States:** IDLE, ACCESS, DONE.
- **IDLE, no memory op:**
  - `stall` = 0.
  - The memory/writeback register loads `alu_result`, `write_reg_addr`, `mem_reg` and `reg_write`. `read_data_buffered` loads 0.
- **IDLE, memory op, misaligned** (`alu_result[1:0]` ≠ 0):
  - No request is issued. `stall` = 0.
  - `mem_error` is set.
  - The memory/writeback register loads with `reg_write_buffered` forced to 0.
- **IDLE, memory op, aligned:**
  - `stall` = 1.
  - Latch the address, write data and write flag.
  - Load a bubble (`reg_write_buffered` = 0, `mem_reg_buffered` = 0).
  - Next state is ACCESS.
- **ACCESS:**
  - `dmem_req` = 1, with `dmem_addr`, `dmem_wdata` and `dmem_we` held from the latches. `stall` = 1. Load a bubble.
  - On `dmem_ready` = 1: capture `dmem_rdata` (0 for writes), then go to DONE.
  - Otherwise increment the wait counter. When the counter reaches `TIMEOUT`-1 with no ready: set `mem_error`, capture data = 0, clear `reg_write` for this instruction, then go to DONE.
- **DONE:**
  - `stall` = 0. `dmem_req` = 0.
  - The memory/writeback register loads the captured data with the instruction's `alu_result`, `write_reg_addr`, `mem_reg` and `reg_write` (after any timeout gating).
  - Next state is IDLE. The upstream register advances at the same edge, so the op is not reissued.
- **Branch:** `pc_src` = `branch & alu_zero`, combinational and independent of state. `branch_target` = `branch_result`.
- **Idle memory port:** `dmem_ready` is ignored while `dmem_req` = 0.
- **`mem_error`:** cleared only by reset.

## Timing
- **Reset:** asynchronous assert.
  - All registered outputs go to 0 (`read_data_buffered`, `alu_result_buffered`, `write_reg_addr_buffered`, `mem_reg_buffered`, `reg_write_buffered`, `mem_error`).
  - The state goes to IDLE and the wait counter clears.
  - `dmem_req`, `dmem_we` and `stall` are 0 during reset.
  - Reset mid-ACCESS drops the request immediately. The instruction is lost and no write-back occurs.
- **Non-memory instruction:** 1 cycle in this stage. Results appear on the memory/writeback outputs 1 edge after presentation.
- **Memory instruction with zero-wait memory:** 3 cycles (IDLE, ACCESS, DONE), `stall` high for 2 cycles. Results appear after the DONE edge.
- **Wait states:** each cycle of `dmem_ready` low in ACCESS adds 1 cycle.
- **Timeout:** worst case is `TIMEOUT` ACCESS cycles, then DONE.
- **Request stability:** `dmem_req`, `dmem_addr`, `dmem_we` and `dmem_wdata` are derived from state and latches only. They are glitch-free and stable throughout ACCESS.
- **Wait counter width:** $clog2(`TIMEOUT`). It saturates and never wraps inside one access, and clears on leaving ACCESS.

## Structure
- **Shared package `cpu_pkg`:**
  - State enum `mem_state_t` (IDLE, ACCESS, DONE).
  - `WORD_W` = 32, `REG_ADDR_W` = 5.
  - Default `TIMEOUT` value.
- **One sub-module, `mw_pipeline_register`:**
  - Holds the memory/writeback payload.
  - Has `load` and `bubble` controls, plus asynchronous active-low reset.
- **Top level:** the FSM, latches, wait counter and branch logic stay in the top.

## Test plan
- **ALU op:** `alu_result`=0x0000_0010, `reg_write`=1, `write_reg_addr`=5, no memory op -> `stall` never high; after 1 edge `alu_result_buffered`=0x10, `write_reg_addr_buffered`=5, `reg_write_buffered`=1.
- **Load with 2 wait states:** load from 0x0000_0100, `dmem_ready` high on the 3rd ACCESS cycle with rdata 0xDEAD_BEEF -> `dmem_req` high for 3 cycles, `stall` high for 4 cycles; then `read_data_buffered`=0xDEAD_BEEF, `mem_reg_buffered`=1.
- **Store:** store 0xCAFE_0001 to 0x0000_0200 with zero wait -> `dmem_we`=1, `dmem_addr`=0x200, `dmem_wdata`=0xCAFE_0001 for exactly 1 cycle; `reg_write_buffered`=0.
- **Misaligned access:** load at 0x0000_0102 -> no `dmem_req`, `mem_error`=1, `reg_write_buffered`=0, `stall`=0.
- **Timeout and branch:** `TIMEOUT`=4 with `dmem_ready` held low -> `dmem_req` high for 4 cycles, then DONE with data 0, `mem_error`=1. Separately, `branch`=1 with `alu_zero`=1 -> `pc_src`=1 in the same cycle with `branch_target`=`branch_result`.
- **Reset mid-ACCESS:** pulse `rst` low during ACCESS -> `dmem_req`/`stall` drop immediately, all outputs 0, FSM in IDLE.
